// File: rtl/fpga_mem_bist_pkg.sv
// Shared types and helpers for the memory BIST initiator.
package mem_bist_pkg;

  // Mem-net message opcode.
  typedef logic [2:0] t_op;
  localparam t_op MEM_MSG_READ  = 3'd0;
  localparam t_op MEM_MSG_WRITE = 3'd1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WRITE  = 3'd1,
    ST_WDRAIN = 3'd2,
    ST_READ   = 3'd3,
    ST_RDRAIN = 3'd4,
    ST_DONE   = 3'd5
  } t_bist_state;

  // Data word written to / expected from word index idx.
  function automatic logic [31:0] bist_pattern(input logic [31:0] idx);
    return {idx[15:0], ~idx[15:0]};
  endfunction

  // Word index of a byte address relative to the window base.
  function automatic logic [31:0] bist_index(input logic [31:0] addr,
                                             input logic [31:0] base);
    logic [31:0] diff;
    diff = addr - base;
    return {2'b00, diff[31:2]};
  endfunction

endpackage

// File: rtl/fpga_mem_bist_scoreboard.sv
// Response checker: flags a bad response, counts errors (saturating) and
// latches the address of the first one.
module MemBistScoreboard
  import mem_bist_pkg::*;
#(
  parameter int unsigned p_opaq_bits = 8,
  parameter int unsigned p_num_words = 16,
  parameter logic [31:0] p_base_addr = 32'h0000_0000
) (
  input  logic                   mem_clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   check_en,
  input  logic [2:0]             exp_op,
  input  logic [2:0]             resp_op,
  input  logic [p_opaq_bits-1:0] resp_opaque,
  input  logic [31:0]            resp_addr,
  input  logic [31:0]            resp_data,
  output logic [15:0]            err_count,
  output logic [31:0]            first_err_addr
);

  localparam logic [31:0] WIN_BYTES = 32'(p_num_words) << 2;

  logic [31:0] idx;
  logic        in_window;
  logic        bad;

  // Classify the response currently on the bus.
  always_comb begin
    idx       = bist_index(resp_addr, p_base_addr);
    in_window = (resp_addr - p_base_addr) < WIN_BYTES;
    bad       = 1'b0;
    if (resp_op != exp_op)                        bad = 1'b1;
    if (resp_opaque != idx[p_opaq_bits-1:0])      bad = 1'b1;
    if (!in_window)                               bad = 1'b1;
    if ((exp_op == MEM_MSG_READ) && (resp_data != bist_pattern(idx))) bad = 1'b1;
  end

  // Saturating error counter and first-error latch; cleared on each new run.
  always_ff @(posedge mem_clk) begin
    if (rst || clear) begin
      err_count      <= 16'h0000;
      first_err_addr <= 32'h0000_0000;
    end else if (check_en && bad) begin
      if (err_count != 16'hFFFF) err_count <= err_count + 16'h0001;
      if (err_count == 16'h0000) first_err_addr <= resp_addr;
    end
  end

endmodule

// File: rtl/fpga_mem_bist.sv
// Memory BIST initiator: writes a pattern over a word window, reads it back
// and checks every response.
// Handshake: a transfer happens on a rising edge where val and rdy are both
// high; once req_val is high the request message holds until that transfer.
module fpga_mem_bist
  import mem_bist_pkg::*;
#(
  parameter int unsigned p_opaq_bits = 8,
  parameter int unsigned p_num_words = 16,
  parameter logic [31:0] p_base_addr = 32'h0000_0000,
  parameter int unsigned p_max_outst = 2,
  parameter logic [1:0]  p_origin    = 2'b00
) (
  input  logic                   mem_clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   done,
  output logic                   pass,
  output logic [15:0]            err_count,
  output logic [31:0]            first_err_addr,
  output logic [2:0]             dbg_state,
  // request channel
  output logic                   req_val,
  input  logic                   req_rdy,
  output logic [2:0]             req_op,
  output logic [p_opaq_bits-1:0] req_opaque,
  output logic [1:0]             req_origin,
  output logic [31:0]            req_addr,
  output logic [3:0]             req_strb,
  output logic [31:0]            req_data,
  // response channel
  input  logic                   resp_val,
  output logic                   resp_rdy,
  input  logic [2:0]             resp_op,
  input  logic [p_opaq_bits-1:0] resp_opaque,
  input  logic [1:0]             resp_origin,
  input  logic [31:0]            resp_addr,
  input  logic [3:0]             resp_strb,
  input  logic [31:0]            resp_data
);

  // One extra bit so the index of the last word never wraps.
  localparam int IDX_W = $clog2(p_num_words) + 1;
  localparam int OUT_W = $clog2(p_max_outst + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(p_num_words - 1);

  t_bist_state      state;
  logic [IDX_W-1:0] issue_idx;
  logic [OUT_W-1:0] outst;
  logic [OUT_W-1:0] outst_next;
  logic [31:0]      word_idx;
  logic             done_q;
  logic             active;
  logic             req_xfer;
  logic             resp_xfer;
  logic             enter_write;
  logic             read_phase;
  logic             unused_resp_fields;

  assign unused_resp_fields = ^{resp_origin, resp_strb};

  assign active      = (state != ST_IDLE) && (state != ST_DONE);
  assign read_phase  = (state == ST_READ) || (state == ST_RDRAIN);
  assign enter_write = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign req_val     = ((state == ST_WRITE) || (state == ST_READ)) &&
                       (outst < OUT_W'(p_max_outst));
  assign req_xfer    = req_val && req_rdy;
  assign resp_rdy    = 1'b1;
  // Responses outside a run are dropped entirely.
  assign resp_xfer   = resp_val && active;

  // Request message is built from the registered index, so it is stable
  // for as long as req_val waits for rdy.
  assign word_idx   = 32'(issue_idx);
  assign req_op     = read_phase ? MEM_MSG_READ : MEM_MSG_WRITE;
  assign req_opaque = word_idx[p_opaq_bits-1:0];
  assign req_origin = p_origin;
  assign req_addr   = p_base_addr + (word_idx << 2);
  assign req_strb   = 4'hF;
  assign req_data   = read_phase ? 32'h0000_0000 : bist_pattern(word_idx);

  assign done      = done_q;
  assign pass      = done_q && (err_count == 16'h0000);
  assign dbg_state = state;

  // Next value of the in-flight request count.
  always_comb begin
    outst_next = outst;
    case ({req_xfer, resp_xfer})
      2'b10:   outst_next = outst + OUT_W'(1);
      2'b01:   outst_next = outst - OUT_W'(1);
      default: outst_next = outst;
    endcase
  end

  // Test sequencer: write pass, drain, read pass, drain, done.
  always_ff @(posedge mem_clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      issue_idx <= '0;
      outst     <= '0;
      done_q    <= 1'b0;
    end else begin
      outst <= outst_next;
      case (state)
        ST_IDLE: begin
          if (enter_write) begin
            state     <= ST_WRITE;
            issue_idx <= '0;
          end
        end
        ST_WRITE: begin
          if (req_xfer) begin
            if (issue_idx == LAST_IDX) begin
              state     <= ST_WDRAIN;
              issue_idx <= '0;
            end else begin
              issue_idx <= issue_idx + IDX_W'(1);
            end
          end
        end
        ST_WDRAIN: begin
          if (outst_next == '0) state <= ST_READ;
        end
        ST_READ: begin
          if (req_xfer) begin
            if (issue_idx == LAST_IDX) begin
              state     <= ST_RDRAIN;
              issue_idx <= '0;
            end else begin
              issue_idx <= issue_idx + IDX_W'(1);
            end
          end
        end
        ST_RDRAIN: begin
          if (outst_next == '0) begin
            state  <= ST_DONE;
            done_q <= 1'b1;
          end
        end
        ST_DONE: begin
          if (enter_write) begin
            state     <= ST_WRITE;
            issue_idx <= '0;
            done_q    <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  MemBistScoreboard #(
    .p_opaq_bits (p_opaq_bits),
    .p_num_words (p_num_words),
    .p_base_addr (p_base_addr)
  ) u_scoreboard (
    .mem_clk        (mem_clk),
    .rst            (rst),
    .clear          (enter_write),
    .check_en       (resp_xfer),
    .exp_op         (req_op),
    .resp_op        (resp_op),
    .resp_opaque    (resp_opaque),
    .resp_addr      (resp_addr),
    .resp_data      (resp_data),
    .err_count      (err_count),
    .first_err_addr (first_err_addr)
  );

endmodule

// File: tb/tb_fpga_mem_bist.sv
// Bench for fpga_mem_bist: a behavioural memory server answers the BIST,
// a queue of expected requests checks the issued traffic, and injected
// response faults set the expected result of each run.
module tb_fpga_mem_bist;
  import mem_bist_pkg::*;

  localparam int N0 = 16;
  localparam int MAXO = 2;
  localparam logic [31:0] BASE1 = 32'h0000_0100;

  // ---------------- clock / reset ----------------
  logic mem_clk = 1'b0;
  always #5 mem_clk = ~mem_clk;
  logic rst, start, start1;

  // ---------------- DUT 0 (16 words) ----------------
  logic        req_val, req_rdy, resp_val, resp_rdy;
  logic [2:0]  req_op, resp_op, dbg_state;
  logic [7:0]  req_opaque, resp_opaque;
  logic [1:0]  req_origin, resp_origin;
  logic [31:0] req_addr, req_data, resp_addr, resp_data, first_err_addr;
  logic [3:0]  req_strb, resp_strb;
  logic        done, pass;
  logic [15:0] err_count;

  fpga_mem_bist #(.p_opaq_bits(8), .p_num_words(N0), .p_base_addr(32'h0),
                  .p_max_outst(MAXO), .p_origin(2'b00)) dut (
    .mem_clk(mem_clk), .rst(rst), .start(start), .done(done), .pass(pass),
    .err_count(err_count), .first_err_addr(first_err_addr), .dbg_state(dbg_state),
    .req_val(req_val), .req_rdy(req_rdy), .req_op(req_op), .req_opaque(req_opaque),
    .req_origin(req_origin), .req_addr(req_addr), .req_strb(req_strb), .req_data(req_data),
    .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_op(resp_op), .resp_opaque(resp_opaque),
    .resp_origin(resp_origin), .resp_addr(resp_addr), .resp_strb(resp_strb), .resp_data(resp_data)
  );

  // ---------------- DUT 1 (single word) ----------------
  logic        req1_val, req1_rdy, resp1_val, resp1_rdy;
  logic [2:0]  req1_op, resp1_op, dbg1_state;
  logic [7:0]  req1_opaque, resp1_opaque;
  logic [1:0]  req1_origin, resp1_origin;
  logic [31:0] req1_addr, req1_data, resp1_addr, resp1_data, first1_err_addr;
  logic [3:0]  req1_strb, resp1_strb;
  logic        done1, pass1;
  logic [15:0] err1_count;

  fpga_mem_bist #(.p_opaq_bits(8), .p_num_words(1), .p_base_addr(BASE1),
                  .p_max_outst(MAXO), .p_origin(2'b00)) dut1 (
    .mem_clk(mem_clk), .rst(rst), .start(start1), .done(done1), .pass(pass1),
    .err_count(err1_count), .first_err_addr(first1_err_addr), .dbg_state(dbg1_state),
    .req_val(req1_val), .req_rdy(req1_rdy), .req_op(req1_op), .req_opaque(req1_opaque),
    .req_origin(req1_origin), .req_addr(req1_addr), .req_strb(req1_strb), .req_data(req1_data),
    .resp_val(resp1_val), .resp_rdy(resp1_rdy), .resp_op(resp1_op), .resp_opaque(resp1_opaque),
    .resp_origin(resp1_origin), .resp_addr(resp1_addr), .resp_strb(resp1_strb), .resp_data(resp1_data)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected request stream: {op, addr, opaque, data}.
  logic [74:0] exp_q[$];

  function automatic logic [31:0] exp_pattern(input int i);
    int lo;
    lo = i % 65536;
    return 32'(lo * 65536 + (65535 - lo));
  endfunction

  task automatic load_expected();
    exp_q.delete();
    for (int i = 0; i < N0; i++)
      exp_q.push_back({MEM_MSG_WRITE, 32'(4 * i), 8'(i), exp_pattern(i)});
    for (int i = 0; i < N0; i++)
      exp_q.push_back({MEM_MSG_READ, 32'(4 * i), 8'(i), 32'h0});
  endtask

  // ---------------- memory server model for DUT 0 ----------------
  typedef struct {
    int          due;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [7:0]  opaque;
    logic [31:0] data;
  } rsp_t;

  rsp_t        rsp_q[$];
  logic [31:0] mem0 [0:N0-1];
  int          cyc = 0;
  int          rdy_pct = 100;
  int          lat_lo = 1, lat_hi = 1;
  int          corrupt_read_idx = -1;
  int          bad_opq_write_idx = -1;
  bit          presented = 0;
  bit          stalled_prev = 0;
  logic [74:0] stall_msg;

  // A response queued with delay d is consumed d edges after its request.
  always @(negedge mem_clk) begin
    logic [74:0] cur_msg;
    rsp_t r;
    int idx;
    cyc++;
    if (presented) begin
      void'(rsp_q.pop_front());
      presented = 0;
    end
    if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
      resp_val = 1'b1;   resp_op = rsp_q[0].op;   resp_addr = rsp_q[0].addr;
      resp_opaque = rsp_q[0].opaque;   resp_data = rsp_q[0].data;
      resp_origin = 2'b00; resp_strb = 4'hF;
      presented = 1;
    end else begin
      resp_val = 1'b0;
    end
    cur_msg = {req_op, req_addr, req_opaque, req_data};
    if (stalled_prev && !rst) begin
      check("stall_val_held", req_val, 1'b1);
      check("stall_msg_stable", cur_msg, stall_msg);
    end
    req_rdy = rst ? 1'b0 : ($urandom_range(99) < rdy_pct);
    if (req_val && !rst)
      check("outst_limit", rsp_q.size() < MAXO, 1'b1);
    if (req_val && req_rdy) begin
      if (exp_q.size() == 0) check("unexpected_req", cur_msg, 75'h0);
      else check("req_msg", cur_msg, exp_q.pop_front());
      check("req_strb_origin", {req_strb, req_origin}, {4'hF, 2'b00});
      idx = int'(req_addr >> 2) % N0;
      r.due = cyc + int'($urandom_range(lat_hi, lat_lo));
      r.op = req_op; r.addr = req_addr; r.opaque = req_opaque;
      if (req_op == MEM_MSG_WRITE) begin
        mem0[idx] = req_data;
        r.data = 32'h0;
        if (idx == bad_opq_write_idx) r.opaque = 8'd3;
      end else begin
        r.data = mem0[idx];
        if (idx == corrupt_read_idx) r.data = r.data ^ 32'h1;
      end
      rsp_q.push_back(r);
    end
    stalled_prev = req_val && !req_rdy && !rst;
    stall_msg = cur_msg;
  end

  // ---------------- one-word server for DUT 1 ----------------
  logic [31:0] mem1;
  bit          pend1 = 0;
  bit          corrupt1 = 0;
  logic [2:0]  p1_op;
  logic [31:0] p1_addr, p1_data;
  logic [7:0]  p1_opq;

  always @(negedge mem_clk) begin
    resp1_val = pend1; resp1_op = p1_op; resp1_addr = p1_addr;
    resp1_opaque = p1_opq; resp1_data = p1_data;
    resp1_origin = 2'b00; resp1_strb = 4'hF;
    pend1 = req1_val && !rst;
    if (pend1) begin
      p1_op = req1_op; p1_addr = req1_addr; p1_opq = req1_opaque;
      if (req1_op == MEM_MSG_WRITE) begin
        mem1 = req1_data; p1_data = 32'h0;
      end else begin
        p1_data = corrupt1 ? (mem1 ^ 32'h1) : mem1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge mem_clk); #1;
  endtask

  task automatic run_test(input string name, input int pct, input int lo, input int hi,
                          input int budget, input int exp_err, input logic [31:0] exp_first,
                          input int bound);
    int cycles;
    rdy_pct = pct; lat_lo = lo; lat_hi = hi;
    load_expected();
    tick(); start = 1'b1;
    tick(); start = 1'b0;
    cycles = 1;
    while (!done && cycles < budget) begin
      tick();
      cycles++;
    end
    if (!done) begin
      check({name, "_timeout"}, 0, 1);
    end else begin
      check({name, "_err_count"}, err_count, 16'(exp_err));
      check({name, "_first_err"}, first_err_addr, exp_first);
      check({name, "_pass"}, pass, exp_err == 0);
      check({name, "_all_issued"}, exp_q.size(), 0);
      if (bound > 0) check({name, "_latency_ok"}, cycles <= bound, 1'b1);
    end
    corrupt_read_idx = -1;
    bad_opq_write_idx = -1;
    repeat (3) tick();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int guard;
    rst = 1'b1; start = 1'b0; start1 = 1'b0; req1_rdy = 1'b1;
    resp_val = 1'b0; resp_op = '0; resp_addr = '0; resp_opaque = '0; resp_data = '0;
    resp_origin = '0; resp_strb = '0; req_rdy = 1'b0;
    p1_op = '0; p1_addr = '0; p1_data = '0; p1_opq = '0; mem1 = '0;
    for (int i = 0; i < N0; i++) mem0[i] = 32'hDEAD_BEEF;
    repeat (3) tick();
    check("rst_req_val", req_val, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_pass", pass, 1'b0);
    check("rst_err_count", err_count, 16'h0);
    check("rst_first_err", first_err_addr, 32'h0);
    check("rst_resp_rdy", resp_rdy, 1'b1);
    check("rst_done1", done1, 1'b0);
    rst = 1'b0;
    repeat (2) tick();

    // Reference: always-ready server, one pass, bounded completion time.
    run_test("ref", 100, 1, 1, 200, 0, 32'h0, 2 * N0 + 8);

    // Corrupted read data on word 5.
    corrupt_read_idx = 5;
    run_test("bad_read", 100, 1, 1, 200, 1, 32'h14, 0);

    // Random backpressure and latency.
    run_test("rand_a", 50, 1, 4, 3000, 0, 32'h0, 0);
    run_test("rand_b", 50, 1, 4, 3000, 0, 32'h0, 0);

    // Wrong opaque on the write to address 8.
    bad_opq_write_idx = 2;
    run_test("bad_opq", 100, 1, 2, 400, 1, 32'h8, 0);

    // Reset during the read pass with two reads in flight.
    rdy_pct = 100; lat_lo = 3; lat_hi = 3;
    load_expected();
    tick(); start = 1'b1;
    tick(); start = 1'b0;
    guard = 0;
    while (!(rsp_q.size() == 2 && rsp_q[0].op == MEM_MSG_READ && rsp_q[1].op == MEM_MSG_READ)
           && guard < 300) begin
      tick();
      guard++;
    end
    check("rst_mid_reached_read", guard < 300, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_req_val", req_val, 1'b0);
    check("rst_mid_done", done, 1'b0);
    check("rst_mid_err_count", err_count, 16'h0);
    guard = 0;
    while (rsp_q.size() > 0 && guard < 50) begin
      tick();
      guard++;
    end
    tick();
    check("stale_drained", rsp_q.size(), 0);
    check("stale_err_count", err_count, 16'h0);
    check("stale_done", done, 1'b0);
    check("stale_req_val", req_val, 1'b0);
    run_test("after_rst", 100, 1, 2, 400, 0, 32'h0, 0);

    // Single-word BIST with start held: first run fails, restart clears it.
    corrupt1 = 1;
    start1 = 1'b1;
    guard = 0;
    while (!done1 && guard < 30) begin
      tick();
      guard++;
    end
    check("n1_first_done", done1, 1'b1);
    check("n1_first_err", err1_count, 16'h1);
    check("n1_first_addr", first1_err_addr, BASE1);
    check("n1_first_pass", pass1, 1'b0);
    corrupt1 = 0;
    tick();
    check("n1_restart_done_low", done1, 1'b0);
    check("n1_restart_req_val", req1_val, 1'b1);
    check("n1_restart_op", req1_op, MEM_MSG_WRITE);
    check("n1_restart_err_clr", err1_count, 16'h0);
    guard = 0;
    while (!done1 && guard < 30) begin
      tick();
      guard++;
    end
    check("n1_second_done", done1, 1'b1);
    check("n1_second_pass", pass1, 1'b1);
    check("n1_second_err", err1_count, 16'h0);
    start1 = 1'b0;
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
